// File: rtl/uart_rx_pkt_parser_if.sv
// Byte-stream bundle between the RX FIFO, the packet parser and the payload sink.
// master = parser side; slave = FIFO and payload-sink side.
interface uart_rx_pkt_parser_if #(
  parameter int D_W   = 8,
  parameter int ERR_W = 8
);
  logic [D_W-1:0]   ff_data;
  logic             ff_empty;
  logic             rd_en;
  logic [D_W-1:0]   pl_data;
  logic             pl_valid;
  logic             pl_ready;
  logic             pl_last;
  logic             pkt_ok;
  logic             pkt_err;
  logic [1:0]       err_code;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    input  ff_data, ff_empty, pl_ready,
    output rd_en, pl_data, pl_valid, pl_last, pkt_ok, pkt_err, err_code, err_cnt
  );

  modport slave (
    output ff_data, ff_empty, pl_ready,
    input  rd_en, pl_data, pl_valid, pl_last, pkt_ok, pkt_err, err_code, err_cnt
  );
endinterface

// File: rtl/uart_rx_pkt_parser.sv
// Pops RX FIFO bytes, parses [SOF][LEN][PAYLOAD][CHK] frames and streams payload; 1 byte per 2 clk peak,
// pkt_ok/pkt_err one cycle after the CHK byte. Sink backpressure stalls FIFO pops and freezes the timeout.
module uart_rx_pkt_parser #(
  parameter int             D_W     = 8,
  parameter logic [D_W-1:0] SOF     = 8'hA5,
  parameter int             MAX_LEN = 32,
  parameter int             TIMEOUT = 1024,
  parameter int             ERR_W   = 8
) (
  input  logic clk,
  input  logic rst,
  uart_rx_pkt_parser_if.master bus
);

  localparam int             REM_W    = $clog2(MAX_LEN + 1);
  localparam int             CNT_W    = $clog2(TIMEOUT);
  localparam logic [D_W-1:0] MAX_B    = D_W'(MAX_LEN);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {HUNT, LEN, PAYLOAD, CHK} state_t;

  state_t             state;
  state_t             state_nxt;
  logic               armed;
  logic               inflight;
  logic [D_W-1:0]     rx_byte;
  logic [REM_W-1:0]   remaining;
  logic [D_W-1:0]     chk;
  logic [CNT_W-1:0]   tmo_cnt;

  logic [D_W-1:0]     pl_data_q;
  logic               pl_valid_q;
  logic               pl_last_q;
  logic               pkt_ok_q;
  logic               pkt_err_q;
  logic [1:0]         err_code_q;
  logic [ERR_W-1:0]   err_cnt_q;

  logic               hs;
  logic               stalled;
  logic               slot_free;
  logic               len_ok;
  logic               tmo_cnt_en;
  logic               tmo_hit;

  logic               rd_en_c;
  logic               pl_load;
  logic               len_load;
  logic               ok_set;
  logic               err_set;
  logic [1:0]         err_code_nxt;

  // The FIFO presents data the cycle after a pop, so that cycle is the capture cycle.
  assign rx_byte    = bus.ff_data;
  assign hs         = pl_valid_q & bus.pl_ready;
  assign stalled    = pl_valid_q & ~bus.pl_ready;
  assign slot_free  = ~pl_valid_q | bus.pl_ready;
  assign len_ok     = (rx_byte != '0) && (rx_byte <= MAX_B);
  assign tmo_cnt_en = (state != HUNT) && !inflight && !stalled;
  assign tmo_hit    = tmo_cnt_en && (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= HUNT;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (tmo_hit) begin
      state_nxt = HUNT;
    end else if (inflight) begin
      case (state)
        HUNT:    if (rx_byte == SOF) state_nxt = LEN;
        LEN:     state_nxt = len_ok ? PAYLOAD : HUNT;
        CHK:     state_nxt = HUNT;
        default: state_nxt = state;
      endcase
    end else if (state == PAYLOAD && hs && remaining == '0) begin
      state_nxt = CHK;
    end
  end

  always_comb begin
    rd_en_c      = armed && !bus.ff_empty && !inflight && (state != PAYLOAD || slot_free);
    len_load     = inflight && state == LEN && len_ok;
    pl_load      = inflight && state == PAYLOAD;
    ok_set       = inflight && state == CHK && rx_byte == chk;
    err_set      = 1'b0;
    err_code_nxt = 2'd0;
    if (tmo_hit) begin
      err_set      = 1'b1;
      err_code_nxt = 2'd3;
    end else if (inflight && state == LEN && !len_ok) begin
      err_set      = 1'b1;
      err_code_nxt = 2'd1;
    end else if (inflight && state == CHK && rx_byte != chk) begin
      err_set      = 1'b1;
      err_code_nxt = 2'd2;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed      <= 1'b0;
      inflight   <= 1'b0;
      remaining  <= '0;
      chk        <= '0;
      tmo_cnt    <= '0;
      pl_data_q  <= '0;
      pl_valid_q <= 1'b0;
      pl_last_q  <= 1'b0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= 2'd0;
      err_cnt_q  <= '0;
    end else begin
      armed    <= 1'b1;
      inflight <= rd_en_c;

      if (state == HUNT || inflight || tmo_hit) begin
        tmo_cnt <= '0;
      end else if (tmo_cnt_en) begin
        tmo_cnt <= tmo_cnt + CNT_W'(1);
      end

      if (len_load) begin
        remaining <= rx_byte[REM_W-1:0];
        chk       <= rx_byte;
      end

      // A byte is only popped in PAYLOAD when the slot is free, so load and handshake never collide.
      if (pl_load) begin
        pl_data_q  <= rx_byte;
        pl_valid_q <= 1'b1;
        pl_last_q  <= (remaining == REM_W'(1));
        chk        <= chk ^ rx_byte;
        remaining  <= remaining - REM_W'(1);
      end else if (hs) begin
        pl_valid_q <= 1'b0;
        pl_last_q  <= 1'b0;
      end

      pkt_ok_q  <= ok_set;
      pkt_err_q <= err_set;
      if (err_set) begin
        err_code_q <= err_code_nxt;
        if (err_cnt_q != '1) begin
          err_cnt_q <= err_cnt_q + ERR_W'(1);
        end
      end
    end
  end

  assign bus.rd_en    = rd_en_c;
  assign bus.pl_data  = pl_data_q;
  assign bus.pl_valid = pl_valid_q;
  assign bus.pl_last  = pl_last_q;
  assign bus.pkt_ok   = pkt_ok_q;
  assign bus.pkt_err  = pkt_err_q;
  assign bus.err_code = err_code_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_uart_rx_pkt_parser.sv
// Directed bench: a byte-queue FIFO model feeds the parser; a negedge monitor logs payload and status pulses.
module tb_uart_rx_pkt_parser;

  localparam int TIMEOUT = 1024;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  uart_rx_pkt_parser_if #(.D_W(8), .ERR_W(8)) bif ();

  uart_rx_pkt_parser #(
    .D_W(8), .SOF(8'hA5), .MAX_LEN(32), .TIMEOUT(TIMEOUT), .ERR_W(8)
  ) dut (
    .clk(clk),
    .rst(rst_n),
    .bus(bif)
  );

  // FIFO model: data appears the cycle after a pop.
  logic [7:0] mem [0:8191];
  int wr_ptr = 0;
  int rd_ptr = 0;

  assign bif.ff_empty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (bif.rd_en && rd_ptr != wr_ptr) begin
      bif.ff_data <= mem[rd_ptr];
      rd_ptr      <= rd_ptr + 1;
    end
  end

  logic [8:0] pl_log [0:4095];
  int         pl_n = 0;
  int         ok_n = 0;
  int         err_n = 0;
  int         both_n = 0;
  int         bad_rd_n = 0;
  logic [1:0] err_code_log = 2'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bif.pl_valid && bif.pl_ready) begin
        pl_log[pl_n] = {bif.pl_last, bif.pl_data};
        pl_n = pl_n + 1;
      end
      if (bif.pkt_ok) ok_n = ok_n + 1;
      if (bif.pkt_err) begin
        err_n = err_n + 1;
        err_code_log = bif.err_code;
      end
      if (bif.pkt_ok && bif.pkt_err) both_n = both_n + 1;
      if (bif.rd_en && bif.ff_empty) bad_rd_n = bad_rd_n + 1;
    end
  end

  typedef struct {
    logic [63:0] b;
    int          nb;
    logic [31:0] pl;
    int          npl;
    int          nok;
    int          nerr;
    logic [1:0]  code;
  } vec_t;

  vec_t vt [8];
  int   checks = 0;
  int   errors = 0;
  int   exp_cnt = 0;
  int   pl0, ok0, err0, n, bad;
  logic [7:0] big_chk;
  logic [7:0] pb;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wr_ptr] = b;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int k;
    k = 0;
    while (rd_ptr != wr_ptr && k < 20000) begin
      tick();
      k = k + 1;
    end
    check(name, (k < 20000), 1);
    repeat (12) tick();
  endtask

  task automatic add_err(input int k);
    exp_cnt = (exp_cnt + k > 255) ? 255 : exp_cnt + k;
  endtask

  task automatic apply_vec(input int i);
    vec_t v;
    int   p0, o0, e0;
    v  = vt[i];
    p0 = pl_n;
    o0 = ok_n;
    e0 = err_n;
    for (int k = 0; k < v.nb; k++) push(v.b[63-8*k -: 8]);
    wait_idle($sformatf("v%0d_drain", i));
    check($sformatf("v%0d_npl", i), pl_n - p0, v.npl);
    for (int k = 0; k < v.npl; k++)
      check($sformatf("v%0d_pl%0d", i, k), pl_log[p0+k], {(k == v.npl - 1), v.pl[31-8*k -: 8]});
    check($sformatf("v%0d_ok", i), ok_n - o0, v.nok);
    check($sformatf("v%0d_err", i), err_n - e0, v.nerr);
    if (v.nerr != 0) check($sformatf("v%0d_code", i), err_code_log, v.code);
    add_err(v.nerr);
    check($sformatf("v%0d_cnt", i), bif.err_cnt, exp_cnt);
  endtask

  initial begin
    //             bytes (MSB first)          nb  payload        npl ok err code
    vt[0] = '{64'hA5_03_11_22_33_03_00_00, 6, 32'h11_22_33_00, 3, 1, 0, 2'd0};
    vt[1] = '{64'hA5_03_11_22_33_00_00_00, 6, 32'h11_22_33_00, 3, 0, 1, 2'd2};
    vt[2] = '{64'h00_FF_A5_00_00_00_00_00, 4, 32'h0,           0, 0, 1, 2'd1};
    vt[3] = '{64'hA5_01_7E_7F_00_00_00_00, 4, 32'h7E_00_00_00, 1, 1, 0, 2'd0};
    vt[4] = '{64'hA5_A5_00_00_00_00_00_00, 2, 32'h0,           0, 0, 1, 2'd1};
    vt[5] = '{64'hA5_21_00_00_00_00_00_00, 2, 32'h0,           0, 0, 1, 2'd1};
    vt[6] = '{64'hA5_02_C3_3C_FD_00_00_00, 5, 32'hC3_3C_00_00, 2, 1, 0, 2'd0};
    vt[7] = '{64'hA5_02_C3_3C_FC_00_00_00, 5, 32'hC3_3C_00_00, 2, 0, 1, 2'd2};

    rst_n = 1'b0;
    bif.pl_ready = 1'b1;
    push(8'h00);
    repeat (3) tick();
    check("rst_rd_en", bif.rd_en, 0);
    check("rst_pl_valid", bif.pl_valid, 0);
    check("rst_pl_last", bif.pl_last, 0);
    check("rst_pl_data", bif.pl_data, 0);
    check("rst_pkt_ok", bif.pkt_ok, 0);
    check("rst_pkt_err", bif.pkt_err, 0);
    check("rst_err_code", bif.err_code, 0);
    check("rst_err_cnt", bif.err_cnt, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) apply_vec(i);

    // Longest legal frame.
    pl0 = pl_n; ok0 = ok_n; err0 = err_n;
    big_chk = 8'h20;
    push(8'hA5);
    push(8'h20);
    for (int i = 0; i < 32; i++) begin
      pb = 8'(i * 7 + 1);
      big_chk = big_chk ^ pb;
      push(pb);
    end
    push(big_chk);
    wait_idle("max_drain");
    check("max_npl", pl_n - pl0, 32);
    bad = 0;
    for (int i = 0; i < 32; i++)
      if (pl_log[pl0+i] !== {(i == 31), 8'(i * 7 + 1)}) bad = bad + 1;
    check("max_pl_bytes", bad, 0);
    check("max_ok", ok_n - ok0, 1);
    check("max_err", err_n - err0, 0);

    // Inter-byte timeout with a payload byte already presented.
    pl0 = pl_n; ok0 = ok_n; err0 = err_n;
    push(8'hA5); push(8'h02); push(8'h55);
    n = 0;
    while (pl_n == pl0 && n < 200) begin tick(); n = n + 1; end
    check("tmo_pl_seen", pl_n - pl0, 1);
    n = 0;
    while (err_n == err0 && n < TIMEOUT + 100) begin tick(); n = n + 1; end
    check("tmo_not_early", (n >= TIMEOUT - 20), 1);
    check("tmo_not_late", (n <= TIMEOUT + 20), 1);
    check("tmo_code", err_code_log, 3);
    check("tmo_pl", pl_log[pl0], {1'b0, 8'h55});
    check("tmo_ok", ok_n - ok0, 0);
    add_err(1);
    check("tmo_cnt", bif.err_cnt, exp_cnt);
    apply_vec(3);

    // Long sink stall mid-payload: data frozen, no pops, no timeout.
    bif.pl_ready = 1'b0;
    pl0 = pl_n; ok0 = ok_n; err0 = err_n;
    for (int k = 0; k < 6; k++) push(vt[0].b[63-8*k -: 8]);
    n = 0;
    while (!bif.pl_valid && n < 200) begin tick(); n = n + 1; end
    check("stall_pl_seen", bif.pl_valid, 1);
    bad = 0;
    repeat (TIMEOUT + 100) begin
      tick();
      if (bif.pl_data !== 8'h11 || bif.pl_valid !== 1'b1 || bif.rd_en !== 1'b0 || bif.pl_last !== 1'b0)
        bad = bad + 1;
    end
    check("stall_hold", bad, 0);
    check("stall_no_err", err_n - err0, 0);
    bif.pl_ready = 1'b1;
    wait_idle("stall_drain");
    check("stall_npl", pl_n - pl0, 3);
    check("stall_pl2", pl_log[pl0+2], {1'b1, 8'h33});
    check("stall_ok", ok_n - ok0, 1);

    // Error counter saturation.
    err0 = err_n; ok0 = ok_n;
    for (int i = 0; i < 259; i++) begin
      push(8'hA5);
      push(8'h00);
    end
    wait_idle("sat_drain");
    check("sat_err_pulses", err_n - err0, 259);
    add_err(259);
    check("sat_cnt", bif.err_cnt, exp_cnt);
    check("sat_ok", ok_n - ok0, 0);

    // Reset mid-payload; leftover frame bytes must be dropped silently in HUNT.
    bif.pl_ready = 1'b0;
    for (int k = 0; k < 6; k++) push(vt[0].b[63-8*k -: 8]);
    n = 0;
    while (!bif.pl_valid && n < 200) begin tick(); n = n + 1; end
    check("mid_pl_seen", bif.pl_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_pl_valid", bif.pl_valid, 0);
    check("mid_rst_pl_data", bif.pl_data, 0);
    check("mid_rst_rd_en", bif.rd_en, 0);
    check("mid_rst_err_cnt", bif.err_cnt, 0);
    check("mid_rst_err_code", bif.err_code, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    bif.pl_ready = 1'b1;
    exp_cnt = 0;
    pl0 = pl_n; ok0 = ok_n; err0 = err_n;
    for (int k = 0; k < 4; k++) push(vt[3].b[63-8*k -: 8]);
    wait_idle("mid_drain");
    check("mid_npl", pl_n - pl0, 1);
    check("mid_pl", pl_log[pl0], {1'b1, 8'h7E});
    check("mid_ok", ok_n - ok0, 1);
    check("mid_err", err_n - err0, 0);
    check("mid_cnt", bif.err_cnt, 0);

    check("never_ok_and_err", both_n, 0);
    check("no_pop_when_empty", bad_rd_n, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
